// File: rtl/mc_main_fsm.sv
// mc_main_fsm: multicycle main control FSM for the MIPS-subset core.
// Steps the shared-memory datapath through fetch/decode/execute/memory/
// writeback, one step per cycle, stretching memory steps on mem_ready.
// Optional feature macro: MC_FSM_ADDI_EN (enables ADDIEXEC/ADDIWB for addi).
module mc_main_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       i_or_d,
  output logic       ireg_enab,
  output logic [1:0] pc_src,
  output logic       pc_enab,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_srcA,
  output logic [1:0] alu_srcB,
  output logic [2:0] alu_ctrl_sig,
  output logic       mem_enab,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
`ifdef MC_FSM_ADDI_EN
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
`endif
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_FSM_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // State register; reset returns to FETCH asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and output decode. Outputs are gated by rst_n so that a
  // mid-instruction reset drops strobes in the same cycle and FETCH's
  // mem_ready-dependent enables stay low while reset is held.
  always_comb begin
    state_d      = S_FETCH;
    i_or_d       = 1'b0;
    ireg_enab    = 1'b0;
    pc_src       = 2'b00;
    pc_enab      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = 1'b0;
    reg_write    = 1'b0;
    alu_srcA     = 1'b0;
    alu_srcB     = 2'b00;
    alu_ctrl_sig = ALU_ADD;
    mem_enab     = 1'b0;
    retire       = 1'b0;
    illegal      = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          alu_srcB = 2'b01;
          if (mem_ready) begin
            ireg_enab = 1'b1;
            pc_enab   = 1'b1;
            state_d   = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_srcB = 2'b11;
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXECUTE;
            OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_FSM_ADDI_EN
            OP_ADDI:      state_d = S_ADDIEXEC;
`endif
            OP_J:         state_d = S_JUMP;
            default: begin
              illegal = 1'b1;
              retire  = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alu_srcA = 1'b1;
          alu_srcB = 2'b10;
          state_d  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          i_or_d  = 1'b1;
          state_d = mem_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          retire     = 1'b1;
        end
        S_MEMWR: begin
          i_or_d   = 1'b1;
          mem_enab = 1'b1;
          if (mem_ready) retire  = 1'b1;
          else           state_d = S_MEMWR;
        end
        S_EXECUTE: begin
          alu_srcA = 1'b1;
          state_d  = S_ALUWB;
          case (funct)
            6'b100000: alu_ctrl_sig = ALU_ADD;
            6'b100010: alu_ctrl_sig = ALU_SUB;
            6'b100100: alu_ctrl_sig = ALU_AND;
            6'b100101: alu_ctrl_sig = ALU_OR;
            6'b101010: alu_ctrl_sig = ALU_SLT;
            default: begin
              illegal = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_srcA     = 1'b1;
          alu_ctrl_sig = ALU_SUB;
          pc_src       = 2'b01;
          pc_enab      = zero;
          retire       = 1'b1;
        end
`ifdef MC_FSM_ADDI_EN
        S_ADDIEXEC: begin
          alu_srcA = 1'b1;
          alu_srcB = 2'b10;
          state_d  = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
`endif
        S_JUMP: begin
          pc_src  = 2'b10;
          pc_enab = 1'b1;
          retire  = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Testbench for mc_main_fsm: per instruction, builds the expected per-cycle
// sequence from the instruction class and wait counts, then applies it.
module tb_mc_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       i_or_d, ireg_enab, pc_enab, mem_to_reg, reg_dst, reg_write;
  logic       alu_srcA, mem_enab, retire, illegal;
  logic [1:0] pc_src, alu_srcB;
  logic [2:0] alu_ctrl_sig;
  logic [3:0] state;

  mc_main_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .i_or_d(i_or_d), .ireg_enab(ireg_enab),
    .pc_src(pc_src), .pc_enab(pc_enab), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_srcA(alu_srcA),
    .alu_srcB(alu_srcB), .alu_ctrl_sig(alu_ctrl_sig), .mem_enab(mem_enab),
    .retire(retire), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       i_or_d, ireg_enab;
    logic [1:0] pc_src;
    logic       pc_enab, mem_to_reg, reg_dst, reg_write, alu_srcA;
    logic [1:0] alu_srcB;
    logic [2:0] alu;
    logic       mem_enab, retire, illegal;
  } exp_t;

  typedef struct {
    exp_t e;
    logic mr;
  } cyc_t;

  cyc_t plan[$];
  int unsigned nvec = 0;
  int unsigned nerr = 0;

  function automatic exp_t blank(input logic [3:0] s);
    exp_t e;
    e     = '0;
    e.st  = s;
    e.alu = 3'b010;
    return e;
  endfunction

  task automatic add(input exp_t e, input logic mr);
    cyc_t c;
    c.e  = e;
    c.mr = mr;
    plan.push_back(c);
  endtask

  task automatic check(input string tag, input exp_t e);
    exp_t got;
    got = {state, i_or_d, ireg_enab, pc_src, pc_enab, mem_to_reg, reg_dst,
           reg_write, alu_srcA, alu_srcB, alu_ctrl_sig, mem_enab, retire, illegal};
    nvec++;
    assert (got === e) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, e);
    end
  endtask

  // Expected cycle list for one instruction, written from the instruction's
  // step list: fetch (wf waits), decode, then the class-specific steps.
  task automatic build(input logic [5:0] op_v, input logic [5:0] fn,
                       input logic z, input int unsigned wf, input int unsigned wm);
    exp_t e;
    bit   ok;
    logic [2:0] a;
    plan.delete();
    e = blank(4'd0);
    e.alu_srcB = 2'b01;
    for (int unsigned i = 0; i < wf; i++) add(e, 1'b0);
    e.ireg_enab = 1'b1;
    e.pc_enab   = 1'b1;
    add(e, 1'b1);
    e = blank(4'd1);
    e.alu_srcB = 2'b11;
    ok = (op_v == 6'b100011) || (op_v == 6'b101011) || (op_v == 6'b000000) ||
         (op_v == 6'b000100) || (op_v == 6'b000010);
`ifdef MC_FSM_ADDI_EN
    if (op_v == 6'b001000) ok = 1'b1;
`endif
    if (!ok) begin
      e.illegal = 1'b1;
      e.retire  = 1'b1;
      add(e, 1'($urandom));
      return;
    end
    add(e, 1'($urandom));
    if (op_v == 6'b100011 || op_v == 6'b101011) begin
      e = blank(4'd2);
      e.alu_srcA = 1'b1;
      e.alu_srcB = 2'b10;
      add(e, 1'($urandom));
      if (op_v == 6'b100011) begin
        e = blank(4'd3);
        e.i_or_d = 1'b1;
        for (int unsigned i = 0; i < wm; i++) add(e, 1'b0);
        add(e, 1'b1);
        e = blank(4'd4);
        e.mem_to_reg = 1'b1;
        e.reg_write  = 1'b1;
        e.retire     = 1'b1;
        add(e, 1'($urandom));
      end else begin
        e = blank(4'd5);
        e.i_or_d   = 1'b1;
        e.mem_enab = 1'b1;
        for (int unsigned i = 0; i < wm; i++) add(e, 1'b0);
        e.retire = 1'b1;
        add(e, 1'b1);
      end
    end else if (op_v == 6'b000000) begin
      e = blank(4'd6);
      e.alu_srcA = 1'b1;
      ok = 1'b1;
      case (fn)
        6'b100000: a = 3'b010;
        6'b100010: a = 3'b110;
        6'b100100: a = 3'b000;
        6'b100101: a = 3'b001;
        6'b101010: a = 3'b111;
        default: begin a = 3'b010; ok = 1'b0; end
      endcase
      e.alu = a;
      if (!ok) begin
        e.illegal = 1'b1;
        e.retire  = 1'b1;
        add(e, 1'($urandom));
        return;
      end
      add(e, 1'($urandom));
      e = blank(4'd7);
      e.reg_dst   = 1'b1;
      e.reg_write = 1'b1;
      e.retire    = 1'b1;
      add(e, 1'($urandom));
    end else if (op_v == 6'b000100) begin
      e = blank(4'd8);
      e.alu_srcA = 1'b1;
      e.alu      = 3'b110;
      e.pc_src   = 2'b01;
      e.pc_enab  = z;
      e.retire   = 1'b1;
      add(e, 1'($urandom));
    end else if (op_v == 6'b000010) begin
      e = blank(4'd11);
      e.pc_src  = 2'b10;
      e.pc_enab = 1'b1;
      e.retire  = 1'b1;
      add(e, 1'($urandom));
    end else begin
      e = blank(4'd9);
      e.alu_srcA = 1'b1;
      e.alu_srcB = 2'b10;
      add(e, 1'($urandom));
      e = blank(4'd10);
      e.reg_write = 1'b1;
      e.retire    = 1'b1;
      add(e, 1'($urandom));
    end
  endtask

  // Apply the plan from posedge+1; check each cycle at the falling edge.
  // stop_st >= 0 ends right after checking the first cycle in that state.
  task automatic run(input string tag, input logic [5:0] op_v, input logic [5:0] fn,
                     input logic z, input int unsigned wf, input int unsigned wm,
                     input int stop_st);
    build(op_v, fn, z, wf, wm);
    foreach (plan[i]) begin
      op        = (plan[i].e.st == 4'd0) ? 6'($urandom) : op_v;
      funct     = (plan[i].e.st == 4'd0) ? 6'($urandom) : fn;
      zero      = z;
      mem_ready = plan[i].mr;
      @(negedge clk);
      check(tag, plan[i].e);
      if (stop_st >= 0 && int'(plan[i].e.st) == stop_st) return;
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] ops [8];
  logic [5:0] fns [6];

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    op        = '0;
    funct     = '0;
    zero      = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset", blank(4'd0));
      @(posedge clk);
    end
    #1 rst_n = 1'b1;

    run("lw",        6'b100011, 6'd0,      1'b0, 0, 0, -1);
    run("sw_wait2",  6'b101011, 6'd0,      1'b0, 0, 2, -1);
    run("r_slt",     6'b000000, 6'b101010, 1'b0, 0, 0, -1);
    run("r_badfn",   6'b000000, 6'b111111, 1'b0, 0, 0, -1);
    run("beq_z1",    6'b000100, 6'd0,      1'b1, 0, 0, -1);
    run("beq_z0",    6'b000100, 6'd0,      1'b0, 1, 0, -1);
    run("j",         6'b000010, 6'd0,      1'b0, 0, 0, -1);
    run("addi",      6'b001000, 6'd0,      1'b0, 0, 0, -1);
    run("bad_op",    6'b111111, 6'd0,      1'b0, 2, 0, -1);
    run("lw_wait",   6'b100011, 6'd0,      1'b0, 1, 3, -1);

    // Reset asserted while a store strobe is active must drop it at once.
    run("sw_abort",  6'b101011, 6'd0,      1'b0, 0, 3, 5);
    #2 rst_n = 1'b0;
    #1 check("mid_reset", blank(4'd0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
            6'b001000, 6'b000010, 6'b000000, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    for (int n = 0; n < 150; n++) begin
      logic [5:0] o, f;
      o = ops[$urandom_range(0, 7)];
      if (n % 7 == 6) o = 6'($urandom);
      f = fns[$urandom_range(0, 5)];
      if (f == 6'b000000) f = 6'($urandom);
      run("random", o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
